// File: rtl/pet_prg_loader_if.sv
// Purpose : bundles the hps_io download stream and the pet2001hw DMA write port seen by pet_prg_loader.
// Latency : n/a (signal bundle only).
// Backpr. : ioctl_wait throttles the byte stream; dma_req is held until dma_ack.
// Ports   : ioctl_* download stream, dma_* single-byte write port, busy/end_addr status.
interface pet_prg_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        dma_req;
    logic        dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        busy;
    logic [15:0] end_addr;

    // loader side
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_ack,
        output ioctl_wait, dma_req, dma_addr, dma_din, busy, end_addr
    );

    // hps_io / pet2001hw side
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_ack,
        input  ioctl_wait, dma_req, dma_addr, dma_din, busy, end_addr
    );
endinterface

// File: rtl/pet_prg_loader.sv
// Purpose : turns the hps_io ioctl byte stream (PRG or ROM image) into single-byte pet2001hw DMA writes,
//           then writes the PRG end address into the BASIC end-of-program pointer.
// Latency : dma_req/addr/din appear 1 cycle after the queuing ioctl_wr.
// Backpr. : one-entry write buffer; ioctl_wait is high while it is full (until the cycle after dma_ack).
// Ports   : clk_sys, reset_n (async, active low); io_bus carries ioctl_*, dma_*, busy, end_addr.
module pet_prg_loader #(
    parameter logic [7:0]  PRG_INDEX = 8'h41,
    parameter logic [7:0]  ROM_INDEX = 8'h00,
    parameter logic [15:0] RAM_TOP   = 16'h8000,
    parameter logic [15:0] PTR_ADDR  = 16'h002A,
    parameter logic [15:0] ROM_MIN   = 16'h0400,
    parameter logic [15:0] ROM_MAX   = 16'h8000,
    parameter logic [15:0] ROM_OFS   = 16'h8000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    pet_prg_loader_if.slave    io_bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_HDR_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PTR_LO = 3'd4;
    localparam logic [2:0] S_PTR_HI = 3'd5;

    logic [2:0]  r_state;
    logic        r_rom;        // 1 = ROM-image mode, 0 = PRG mode
    logic        r_dl_prev;
    logic        r_pend;       // download started while a previous load was still finishing
    logic [7:0]  r_pend_idx;
    logic [15:0] r_cur_addr;
    logic [15:0] r_end_addr;
    logic        r_req;
    logic [15:0] r_dma_addr;
    logic [7:0]  r_dma_din;

    logic        w_dl;
    logic        w_rise;
    logic        w_ack;
    logic        w_rom_hit;
    logic        w_start;
    logic [7:0]  w_start_idx;

    assign w_dl        = io_bus.ioctl_download;
    assign w_rise      = w_dl & ~r_dl_prev;
    assign w_ack       = r_req & io_bus.dma_ack;
    assign w_rom_hit   = (io_bus.ioctl_addr >= {9'd0, ROM_MIN}) && (io_bus.ioctl_addr < {9'd0, ROM_MAX});
    // A deferred start is only honoured if that download is still running.
    assign w_start     = (r_state == S_IDLE) && (w_rise || (r_pend && w_dl));
    assign w_start_idx = w_rise ? io_bus.ioctl_index : r_pend_idx;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rom      <= 1'b0;
            r_dl_prev  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_idx <= 8'd0;
            r_cur_addr <= 16'd0;
            r_end_addr <= 16'd0;
            r_req      <= 1'b0;
            r_dma_addr <= 16'd0;
            r_dma_din  <= 8'd0;
        end else begin
            r_dl_prev <= w_dl;
            if (w_ack) r_req <= 1'b0;

            // A rising edge can only hit a busy FSM while it is draining or writing the pointer.
            if (w_rise && (r_state != S_IDLE)) begin
                r_pend     <= 1'b1;
                r_pend_idx <= io_bus.ioctl_index;
            end

            case (r_state)
                S_IDLE: begin
                    r_pend <= 1'b0;
                    if (w_start) begin
                        if (w_start_idx == PRG_INDEX) begin
                            r_rom   <= 1'b0;
                            r_state <= S_HDR_LO;
                        end else if (w_start_idx == ROM_INDEX) begin
                            r_rom   <= 1'b1;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_HDR_LO: begin
                    if (!w_dl) begin
                        r_state <= S_IDLE;
                    end else if (io_bus.ioctl_wr) begin
                        r_cur_addr[7:0] <= io_bus.ioctl_dout;
                        r_state         <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (!w_dl) begin
                        r_state <= S_IDLE;
                    end else if (io_bus.ioctl_wr) begin
                        r_cur_addr[15:8] <= io_bus.ioctl_dout;
                        r_state          <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!w_dl) begin
                        // cur_addr is frozen once the download ends, so latching it every cycle is safe.
                        if (!r_rom) r_end_addr <= r_cur_addr;
                        if (!r_req) r_state <= r_rom ? S_IDLE : S_PTR_LO;
                    end else if (io_bus.ioctl_wr && !r_req) begin
                        if (r_rom) begin
                            if (w_rom_hit) begin
                                r_req      <= 1'b1;
                                r_dma_addr <= io_bus.ioctl_addr[15:0] + ROM_OFS;
                                r_dma_din  <= io_bus.ioctl_dout;
                            end
                        end else if (r_cur_addr < RAM_TOP) begin
                            r_req      <= 1'b1;
                            r_dma_addr <= r_cur_addr;
                            r_dma_din  <= io_bus.ioctl_dout;
                            r_cur_addr <= r_cur_addr + 16'd1;
                        end
                    end
                end
                S_PTR_LO: begin
                    if (!r_req) begin
                        r_req      <= 1'b1;
                        r_dma_addr <= PTR_ADDR;
                        r_dma_din  <= r_end_addr[7:0];
                    end else if (w_ack) begin
                        r_state <= S_PTR_HI;
                    end
                end
                S_PTR_HI: begin
                    if (!r_req) begin
                        r_req      <= 1'b1;
                        r_dma_addr <= PTR_ADDR + 16'd1;
                        r_dma_din  <= r_end_addr[15:8];
                    end else if (w_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Holding off a deferred download keeps its bytes from arriving before the pointer writes finish.
    assign io_bus.ioctl_wait = r_req | r_pend;
    assign io_bus.dma_req    = r_req;
    assign io_bus.dma_addr   = r_dma_addr;
    assign io_bus.dma_din    = r_dma_din;
    assign io_bus.busy       = (r_state != S_IDLE) && !((r_state == S_DATA) && r_rom);
    assign io_bus.end_addr   = r_end_addr;

endmodule

// File: tb/tb_pet_prg_loader.sv
// Purpose : directed stimulus for pet_prg_loader with a queue-based scoreboard on the DMA port.
// Latency : expects DMA request 1 cycle after each queuing ioctl_wr.
// Backpr. : DMA responder acks after a programmable delay; the byte source honours ioctl_wait.
module tb_pet_prg_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pet_prg_loader_if bus();

    pet_prg_loader dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dat;
    } dma_t;

    dma_t exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   ack_delay = 0;
    bit   ack_en    = 1'b1;
    int   dma_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte source: waits (bounded) for ioctl_wait low, then strobes one byte.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int t = 0;
        while (bus.ioctl_wait && t < 100) begin
            tick(1);
            t++;
        end
        check("wait_release", {31'd0, bus.ioctl_wait}, 32'd0);
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        tick(1);
        bus.ioctl_wr   = 1'b0;
        tick(1);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((bus.busy || bus.dma_req || exp_q.size() != 0) && t < 500) begin
            tick(1);
            t++;
        end
        check({name, "_idle"}, {30'd0, bus.busy, bus.dma_req}, 32'd0);
        check({name, "_qempty"}, exp_q.size(), 32'd0);
    endtask

    // DMA responder + scoreboard monitor: pops the expected write whenever it acks one.
    initial begin
        bit   have_ref;
        dma_t ref_v;
        dma_t e;
        int   cnt;
        bus.dma_ack = 1'b0;
        have_ref    = 1'b0;
        cnt         = 0;
        forever begin
            @(negedge clk);
            if (bus.dma_ack) begin
                bus.dma_ack = 1'b0;
                cnt         = 0;
                have_ref    = 1'b0;
            end else if (bus.dma_req && ack_en) begin
                if (!have_ref) begin
                    ref_v    = {bus.dma_addr, bus.dma_din};
                    have_ref = 1'b1;
                end else begin
                    check("stable_addr", bus.dma_addr, ref_v.addr);
                    check("stable_din", bus.dma_din, ref_v.dat);
                    check("wait_held", {31'd0, bus.ioctl_wait}, 32'd1);
                end
                if (cnt >= ack_delay) begin
                    bus.dma_ack = 1'b1;
                    dma_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dma: got %h=%h expected none", bus.dma_addr, bus.dma_din);
                    end else begin
                        e = exp_q.pop_front();
                        check("dma_addr", bus.dma_addr, e.addr);
                        check("dma_din", bus.dma_din, e.dat);
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    logic [24:0] rom_ofs [10] = '{25'h0000000, 25'h0000001, 25'h00003FF, 25'h0000400, 25'h0000401,
                                  25'h0004000, 25'h0007FFF, 25'h0008000, 25'h000FFFF, 25'h0010400};

    initial begin
        int t;
        int seen0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'h00;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;

        // Reset state
        tick(2);
        check("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        check("rst_req", {31'd0, bus.dma_req}, 32'd0);
        check("rst_addr", bus.dma_addr, 32'd0);
        check("rst_din", bus.dma_din, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_end", bus.end_addr, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // 1: small PRG at 0401
        push(16'h0401, 8'hAA); push(16'h0402, 8'hBB); push(16'h0403, 8'hCC);
        push(16'h002A, 8'h04); push(16'h002B, 8'h04);
        start_dl(8'h41);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        send_byte(25'd0, 8'h01); send_byte(25'd1, 8'h04);
        send_byte(25'd2, 8'hAA); send_byte(25'd3, 8'hBB); send_byte(25'd4, 8'hCC);
        end_dl();
        wait_idle("t1");
        check("t1_end", bus.end_addr, 32'h0404);

        // 2: PRG crossing RAM_TOP
        push(16'h7FFE, 8'h11); push(16'h7FFF, 8'h22);
        push(16'h002A, 8'h00); push(16'h002B, 8'h80);
        start_dl(8'h41);
        send_byte(25'd0, 8'hFE); send_byte(25'd1, 8'h7F);
        send_byte(25'd2, 8'h11); send_byte(25'd3, 8'h22);
        send_byte(25'd4, 8'h33); send_byte(25'd5, 8'h44);
        end_dl();
        wait_idle("t2");
        check("t2_end", bus.end_addr, 32'h8000);

        // 3: ROM image window boundaries
        seen0 = dma_seen;
        push(16'h8400, 8'h13); push(16'h8401, 8'h14);
        push(16'hC000, 8'h15); push(16'hFFFF, 8'h16);
        start_dl(8'h00);
        check("t3_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 10; i++) send_byte(rom_ofs[i], 8'(8'h10 + i));
        end_dl();
        wait_idle("t3");
        check("t3_count", dma_seen - seen0, 32'd4);
        check("t3_end", bus.end_addr, 32'h8000);

        // 4: slow ack, buffer must hold and back-pressure
        ack_delay = 5;
        push(16'h1000, 8'h5A); push(16'h1001, 8'hA5);
        push(16'h002A, 8'h02); push(16'h002B, 8'h10);
        start_dl(8'h41);
        send_byte(25'd0, 8'h00); send_byte(25'd1, 8'h10);
        send_byte(25'd2, 8'h5A);
        check("t4_wait", {31'd0, bus.ioctl_wait}, 32'd1);
        check("t4_addr", bus.dma_addr, 32'h1000);
        send_byte(25'd3, 8'hA5);
        end_dl();
        wait_idle("t4");
        check("t4_end", bus.end_addr, 32'h1002);
        ack_delay = 0;

        // 5: one-byte PRG
        seen0 = dma_seen;
        start_dl(8'h41);
        send_byte(25'd0, 8'hAB);
        end_dl();
        tick(5);
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_req", {31'd0, bus.dma_req}, 32'd0);
        check("t5_count", dma_seen - seen0, 32'd0);
        check("t5_end", bus.end_addr, 32'h1002);

        // 6: reset during PTR_LO, then a normal load
        push(16'h2000, 8'h77);
        start_dl(8'h41);
        send_byte(25'd0, 8'h00); send_byte(25'd1, 8'h20); send_byte(25'd2, 8'h77);
        tick(3);
        ack_en = 1'b0;
        end_dl();
        t = 0;
        while (!bus.dma_req && t < 20) begin
            tick(1);
            t++;
        end
        check("t6_ptr_addr", bus.dma_addr, 32'h002A);
        check("t6_ptr_din", bus.dma_din, 32'h01);
        check("t6_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_out", {bus.ioctl_wait, bus.dma_req, bus.busy, bus.dma_addr, bus.dma_din}, 32'd0);
        check("t6_rst_end", bus.end_addr, 32'd0);
        tick(1);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        tick(2);
        push(16'h3000, 8'h99); push(16'h002A, 8'h01); push(16'h002B, 8'h30);
        start_dl(8'h41);
        send_byte(25'd0, 8'h00); send_byte(25'd1, 8'h30); send_byte(25'd2, 8'h99);
        end_dl();
        wait_idle("t6");
        check("t6_end", bus.end_addr, 32'h3001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
